// File: rtl/dram_access_sequencer.sv
// Single-outstanding DRAM access sequencer: validates and lane-steers one load/store,
// drives a req/ack word port with a response timeout, and returns extended load data.
module dram_access_sequencer #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_we,
  input  logic        i_le,
  input  logic [2:0]  i_ctrl,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  output logic        o_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg;
  logic        we_reg;
  logic [2:0]  ctrl_reg;
  logic [1:0]  addr_lo_reg;
  logic [31:0] m_addr_reg;
  logic [31:0] m_wdata_reg;
  logic [3:0]  m_wstrb_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic        req_present;
  logic        chk_fail;
  logic        timeout_hit;
  logic [31:0] byte_rep, half_rep;
  logic [31:0] wdata_steer;
  logic [3:0]  wstrb_steer;
  logic [7:0]  rd_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_rep[8*gi +: 8] = i_wdata[7:0];
      assign rd_lane[gi]         = m_rdata[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign half_rep[16*gi +: 16] = i_wdata[15:0];
    end
  endgenerate

  assign req_present = i_we | i_le;
  assign chk_fail    = (i_we & i_le)
                     | (i_ctrl[1:0] == 2'b11)
                     | ((i_ctrl[1:0] == 2'b01) & i_addr[0])
                     | ((i_ctrl[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));
  // An ack in the final allowed cycle wins over the timeout (ack is checked first).
  assign timeout_hit = ({1'b0, cnt_reg} + 9'd1) == TIMEOUT_W;

  always_comb begin
    wdata_steer = i_wdata;
    wstrb_steer = 4'b1111;
    case (i_ctrl[1:0])
      2'b00: begin
        wdata_steer = byte_rep;
        wstrb_steer = 4'b0001 << i_addr[1:0];
      end
      2'b01: begin
        wdata_steer = half_rep;
        wstrb_steer = 4'b0011 << i_addr[1:0];
      end
      default: ;
    endcase
  end

  assign byte_sel = rd_lane[addr_lo_reg];
  assign half_sel = addr_lo_reg[1] ? m_rdata[31:16] : m_rdata[15:0];

  always_comb begin
    load_ext = m_rdata;
    case (ctrl_reg[1:0])
      2'b00:   load_ext = ctrl_reg[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = ctrl_reg[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_present && !chk_fail) state_next = REQ;
      REQ:     if (m_ack || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_req  = (state_reg == REQ);
    o_busy = (state_reg == REQ);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_reg     <= 8'd0;
      we_reg      <= 1'b0;
      ctrl_reg    <= 3'd0;
      addr_lo_reg <= 2'd0;
      m_addr_reg  <= 32'd0;
      m_wdata_reg <= 32'd0;
      m_wstrb_reg <= 4'd0;
      rdata_reg   <= 32'd0;
      err_reg     <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_present) begin
            if (chk_fail) begin
              err_reg   <= 1'b1;
              rdata_reg <= ERR_RDATA;
            end else begin
              cnt_reg     <= 8'd0;
              we_reg      <= i_we;
              ctrl_reg    <= i_ctrl;
              addr_lo_reg <= i_addr[1:0];
              m_addr_reg  <= {i_addr[31:2], 2'b00};
              m_wdata_reg <= wdata_steer;
              m_wstrb_reg <= wstrb_steer;
            end
          end
        end
        REQ: begin
          cnt_reg <= cnt_reg + 8'd1;
          if (m_ack) begin
            if (!we_reg) rdata_reg <= load_ext;
          end else if (timeout_hit) begin
            err_reg   <= 1'b1;
            rdata_reg <= ERR_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rdata = rdata_reg;
  assign o_err   = err_reg;
  assign m_we    = we_reg;
  assign m_addr  = m_addr_reg;
  assign m_wdata = m_wdata_reg;
  assign m_wstrb = m_wstrb_reg;

endmodule

// File: tb/tb_dram_access_sequencer.sv
// Directed bench for dram_access_sequencer with a short timeout and a distinctive error word.
module tb_dram_access_sequencer;

  localparam logic [31:0] ERR = 32'hDEAD_0BAD;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] i_addr, i_wdata, o_rdata, m_addr, m_wdata, m_rdata;
  logic        i_we, i_le, o_busy, o_err, m_req, m_we, m_ack;
  logic [2:0]  i_ctrl;
  logic [3:0]  m_wstrb;

  int vectors = 0;
  int miscompares = 0;

  dram_access_sequencer #(.TIMEOUT(4), .ERR_RDATA(ERR)) dut (
    .CLK(CLK), .RST(RST),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_we(i_we), .i_le(i_le), .i_ctrl(i_ctrl),
    .o_rdata(o_rdata), .o_busy(o_busy), .o_err(o_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s observed %h expected %h", vectors, tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mreq"}, 32'(m_req), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    RST = 1'b1; i_addr = '0; i_wdata = '0; i_we = 0; i_le = 0; i_ctrl = '0;
    m_ack = 0; m_rdata = '0;
    step(); step();
    RST = 1'b0;
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_wstrb", 32'(m_wstrb), 32'd0);
    chk_idle("rst");

    // Word load, ack in the fourth REQ cycle (same cycle the counter hits TIMEOUT)
    i_le = 1; i_addr = 32'h103; i_addr = 32'h100; i_ctrl = 3'b010;
    step();
    i_le = 0;
    chk("wl_addr", m_addr, 32'h100);
    chk("wl_wstrb", 32'(m_wstrb), 32'hF);
    chk("wl_mwe", 32'(m_we), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("wl_busy", 32'(o_busy), 32'd1);
      chk("wl_mreq", 32'(m_req), 32'd1);
      chk("wl_err", 32'(o_err), 32'd0);
      if (i == 3) begin m_ack = 1; m_rdata = 32'h89AB_CDEF; end
      step();
    end
    m_ack = 0;
    chk_idle("wl_done");
    chk("wl_rdata", o_rdata, 32'h89AB_CDEF);
    chk("wl_err_done", 32'(o_err), 32'd0);
    step();

    // Signed byte load from lane 3; a store strobe in DONE is ignored
    i_le = 1; i_addr = 32'h103; i_ctrl = 3'b000;
    step();
    i_le = 0;
    chk("sb_wstrb", 32'(m_wstrb), 32'h8);
    m_ack = 1; m_rdata = 32'h8012_3456;
    step();
    m_ack = 0;
    chk("sb_rdata", o_rdata, 32'hFFFF_FF80);
    i_we = 1; i_ctrl = 3'b010; i_addr = 32'h600;
    step();
    i_we = 0;
    step();
    chk_idle("done_strobe");

    // Unsigned byte load
    i_le = 1; i_addr = 32'h103; i_ctrl = 3'b100;
    step();
    i_le = 0;
    m_ack = 1;
    step();
    m_ack = 0;
    chk("ub_rdata", o_rdata, 32'h0000_0080);
    step();

    // Half store at upper half
    i_we = 1; i_addr = 32'h202; i_wdata = 32'h0000_BEEF; i_ctrl = 3'b001;
    step();
    i_we = 0;
    chk("hs_mreq", 32'(m_req), 32'd1);
    chk("hs_mwe", 32'(m_we), 32'd1);
    chk("hs_wstrb", 32'(m_wstrb), 32'hC);
    chk("hs_wdata", m_wdata, 32'hBEEF_BEEF);
    chk("hs_addr", m_addr, 32'h200);
    m_ack = 1; m_rdata = 32'h1111_1111;
    step();
    m_ack = 0;
    chk("hs_rdata_kept", o_rdata, 32'h0000_0080);
    step();

    // Rejected requests: misaligned half, illegal size, both strobes
    i_le = 1; i_addr = 32'h101; i_ctrl = 3'b001;
    step();
    i_le = 0;
    chk("e1_err", 32'(o_err), 32'd1);
    chk("e1_rdata", o_rdata, ERR);
    chk_idle("e1");
    step();
    chk("e1_err_clr", 32'(o_err), 32'd0);
    chk_idle("e1_after");

    i_we = 1; i_addr = 32'h100; i_ctrl = 3'b011;
    step();
    i_we = 0;
    chk("e2_err", 32'(o_err), 32'd1);
    chk_idle("e2");
    step();
    chk("e2_err_clr", 32'(o_err), 32'd0);

    i_we = 1; i_le = 1; i_addr = 32'h100; i_ctrl = 3'b010;
    step();
    i_we = 0; i_le = 0;
    chk("e3_err", 32'(o_err), 32'd1);
    chk_idle("e3");
    step();
    chk("e3_err_clr", 32'(o_err), 32'd0);
    chk_idle("e3_after");

    // Timeout: four REQ cycles, then abort
    i_le = 1; i_addr = 32'h300; i_ctrl = 3'b010;
    step();
    i_le = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_mreq", 32'(m_req), 32'd1);
      step();
    end
    chk_idle("to_done");
    chk("to_err", 32'(o_err), 32'd1);
    chk("to_rdata", o_rdata, ERR);
    step();
    m_ack = 1; m_rdata = 32'h1234_5678;
    step();
    m_ack = 0;
    chk("late_ack_rdata", o_rdata, ERR);
    chk("late_ack_err", 32'(o_err), 32'd0);
    chk_idle("late_ack");

    // Reset while in REQ, with an ack arriving alongside
    i_le = 1; i_addr = 32'h400; i_ctrl = 3'b010;
    step();
    i_le = 0;
    chk("rr_mreq", 32'(m_req), 32'd1);
    RST = 1; m_ack = 1; m_rdata = 32'h5555_5555;
    step();
    RST = 0; m_ack = 0;
    chk_idle("rr");
    chk("rr_rdata", o_rdata, 32'd0);
    chk("rr_err", 32'(o_err), 32'd0);

    // Minimum-latency word load after reset
    i_le = 1; i_addr = 32'h500; i_ctrl = 3'b010;
    step();
    i_le = 0;
    chk("ml_busy", 32'(o_busy), 32'd1);
    chk("ml_addr", m_addr, 32'h500);
    m_ack = 1; m_rdata = 32'hCAFE_F00D;
    step();
    m_ack = 0;
    chk("ml_rdata", o_rdata, 32'hCAFE_F00D);
    chk_idle("ml_done");
    chk("ml_err", 32'(o_err), 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
